// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the serial frame receiver: FSM states,
// parity/baud selection codes and the 16x oversampling divisors.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam int DIV_W        = 16;
    localparam int DEF_CLK_FREQ = 50_000_000;

    // Clocks per oversampling tick: clk_freq / (16 * baud), truncated.
    function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input logic [1:0] sel);
        int hz;
        int q;
        case (sel)
            BAUD_2400:  hz = 2400;
            BAUD_4800:  hz = 4800;
            BAUD_9600:  hz = 9600;
            default:    hz = 19200;
        endcase
        q = clk_freq / (16 * hz);
        return q[DIV_W-1:0];
    endfunction

    // Divisors at the default 50 MHz clock (1302 / 651 / 325 / 162).
    localparam logic [DIV_W-1:0] DIV_2400  = baud_div(DEF_CLK_FREQ, BAUD_2400);
    localparam logic [DIV_W-1:0] DIV_4800  = baud_div(DEF_CLK_FREQ, BAUD_4800);
    localparam logic [DIV_W-1:0] DIV_9600  = baud_div(DEF_CLK_FREQ, BAUD_9600);
    localparam logic [DIV_W-1:0] DIV_19200 = baud_div(DEF_CLK_FREQ, BAUD_19200);

endpackage

// File: rtl/rx_frame_unit_baud_tick.sv
// 16x oversampling tick generator. Emits a one-cycle tick every DIV clocks;
// restart realigns the divider so ticks are phased to a detected start edge.
import rx_frame_pkg::*;

module rx_baud_tick #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [1:0] baud_sel,
    output logic       tick
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // At the default clock the published constants are used directly.
    localparam bit USE_DEF = (CLK_FREQ == DEF_CLK_FREQ);
    localparam logic [DIV_W-1:0] D_2400  = USE_DEF ? DIV_2400  : baud_div(CLK_FREQ, BAUD_2400);
    localparam logic [DIV_W-1:0] D_4800  = USE_DEF ? DIV_4800  : baud_div(CLK_FREQ, BAUD_4800);
    localparam logic [DIV_W-1:0] D_9600  = USE_DEF ? DIV_9600  : baud_div(CLK_FREQ, BAUD_9600);
    localparam logic [DIV_W-1:0] D_19200 = USE_DEF ? DIV_19200 : baud_div(CLK_FREQ, BAUD_19200);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_val;

    // Divisor lookup for the selected baud rate.
    always_comb begin
        div_val = D_2400;
        case (baud_sel)
            BAUD_4800:  div_val = D_4800;
            BAUD_9600:  div_val = D_9600;
            BAUD_19200: div_val = D_19200;
            default:    div_val = D_2400;
        endcase
    end

    // >= guards against a count left above a newly smaller divisor.
    assign tick = (div_cnt >= div_val - ONE);

    // Free-running divider, cleared on restart and on every tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (restart || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + ONE;
    end

endmodule

// File: rtl/rx_frame_unit.sv
// Asynchronous serial frame receiver: start bit, 8 data bits LSB first,
// optional parity, one stop bit. Mid-bit sampling on a 16x oversampled grid.
import rx_frame_pkg::*;

module rx_frame_unit #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in_rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       active_flag,
    output logic       done_flag,
    output logic [2:0] error_flag
);

    rx_state_t state, state_nxt;

    logic       rx_sync_p0, rx_sync_p1, rx_prev;
    logic       rx_s;
    logic       tick;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       par_bit;
    logic [1:0] baud_lat;
    logic [1:0] par_lat;
    logic       par_en;
    logic       par_err;
    logic       start_det;
    logic       start_mid;
    logic       bit_mid;
    logic       start_err;
    logic       data_sample;
    logic       par_sample;
    logic       frame_end;

    assign rx_s      = rx_sync_p1;
    assign start_det = (state == ST_IDLE) && rx_prev && !rx_s;
    assign start_mid = tick && (tick_cnt == 4'd7);
    assign bit_mid   = tick && (tick_cnt == 4'd15);
    assign par_en    = (par_lat == PAR_ODD) || (par_lat == PAR_EVEN);

    rx_baud_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud_tick (
        .clk      (clk),
        .reset    (reset),
        .restart  (start_det),
        .baud_sel (baud_lat),
        .tick     (tick)
    );

    // Parity check over the received byte and parity bit.
    always_comb begin
        par_err = 1'b0;
        case (par_lat)
            PAR_ODD:               par_err = ~(^shift_reg ^ par_bit);
            PAR_EVEN:              par_err = ^shift_reg ^ par_bit;
            PAR_NONE, PAR_NONE_ALT: par_err = 1'b0;
            default:               par_err = 1'b0;
        endcase
    end

    // Line synchronizer and edge-detect history; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            rx_sync_p0 <= data_in_rx;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev    <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and per-cycle sample strobes.
    always_comb begin
        state_nxt   = state;
        start_err   = 1'b0;
        data_sample = 1'b0;
        par_sample  = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_det)
                    state_nxt = ST_START;
            end
            ST_START: begin
                if (start_mid) begin
                    if (!rx_s) begin
                        state_nxt = ST_DATA;
                    end else begin
                        start_err = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bit_mid) begin
                    data_sample = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_mid) begin
                    par_sample = 1'b1;
                    state_nxt  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_mid) begin
                    frame_end = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Tick/bit counters, shift register and per-frame configuration latch.
    // The tick counter realigns to 0 at the start mid-point so every later
    // sample lands 16 ticks after the previous one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            par_bit   <= 1'b0;
            baud_lat  <= 2'b00;
            par_lat   <= 2'b00;
        end else begin
            if (start_det) begin
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
                baud_lat <= baud_rate;
                par_lat  <= parity_type;
            end else if (state != ST_IDLE && tick) begin
                if (start_mid && state == ST_START)
                    tick_cnt <= 4'd0;
                else
                    tick_cnt <= tick_cnt + 4'd1;
            end
            if (data_sample) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (par_sample)
                par_bit <= rx_s;
        end
    end

    // Frame outputs: byte, completion pulse, error status and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out    <= 8'h00;
            done_flag   <= 1'b0;
            error_flag  <= 3'b000;
            active_flag <= 1'b0;
        end else begin
            done_flag <= frame_end;
            if (frame_end) begin
                data_out   <= shift_reg;
                error_flag <= {~rx_s, 1'b0, par_err};
            end else if (start_err) begin
                error_flag <= 3'b010;
            end else if (start_det) begin
                error_flag <= 3'b000;
            end
            if (start_det)
                active_flag <= 1'b1;
            else if (start_err || done_flag)
                active_flag <= 1'b0;
        end
    end

endmodule

// File: doc/rx_frame_unit.md
RX_FRAME_UNIT -- requirements
Module: rx_frame_unit

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_in_rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port parity_type  input  2  parity selection:
- 00 = none
- 01 = odd
- 10 = even
- 11 = none
REQ-006 SHALL have port baud_rate  input  2  baud selection:
- 00 = 2400
- 01 = 4800
- 10 = 9600
- 11 = 19200
REQ-007 SHALL have port data_out  output  8  last received data byte.
REQ-008 SHALL have port active_flag  output  1  high while a frame is in progress.
REQ-009 SHALL have port done_flag  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port error_flag  output  3  error bits:
- [0] parity error
- [1] start error
- [2] stop error

Function
REQ-011 SHALL accept frames of 1 start bit (0), 8 data bits LSB first, 1 parity bit only when parity is enabled, and 1 stop bit (1).
REQ-012 SHALL pass data_in_rx through a 2-flop synchronizer before any use.
REQ-013 SHALL generate a 16x oversampling tick using divisor DIV = CLK_FREQ/(16*baud) with integer truncation:
- 2400 -> 1302
- 4800 -> 651
- 9600 -> 325
- 19200 -> 162
REQ-014 SHALL detect a start as a 1->0 transition of the synchronized line while in IDLE; the divider and the tick counter SHALL restart on that cycle.
REQ-015 SHALL latch baud_rate and parity_type at start detection; input changes during a frame SHALL have no effect until the next frame.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY and STOP with these transitions:
- IDLE->START on start detection.
- START->DATA at tick 8, if the line is still low.
- DATA->PARITY, or DATA->STOP when parity is none, after the 8th data sample.
- PARITY->STOP after the parity sample.
- STOP->IDLE after the stop sample.
REQ-017 SHALL sample each data, parity and stop bit 16 ticks after the previous sample, i.e. at mid-bit.
REQ-018 SHALL treat the line high at the START mid-sample as a start error:
- set error_flag to 010.
- return to IDLE.
- issue no done_flag pulse.
- leave data_out unchanged.
REQ-019 SHALL set error_flag[0] when the XOR of the 8 data bits and the received parity bit is 1 for even parity, or 0 for odd parity.
REQ-020 SHALL set error_flag[2] when the stop sample is 0.
REQ-021 SHALL, on the cycle after the stop sample:
- load data_out with the received byte, even when errors are present.
- pulse done_flag for exactly one cycle.
- present error_flag for that frame.
REQ-022 SHALL hold error_flag from frame end until the next start detection, which clears it to 000.
REQ-023 SHALL drive active_flag high from the cycle after start detection until the done_flag cycle, inclusive, or until a start-error abort.
REQ-024 SHALL, after a stop error (line held low), accept no new frame until a fresh 1->0 transition occurs.

Reset
REQ-025 SHALL, while reset is high, asynchronously force:
- state to IDLE.
- data_out to 00.
- active_flag, done_flag and error_flag to 0.
- divider and counters to 0.
- synchronizer flops to 1.
REQ-026 SHALL, when reset is asserted mid-frame, discard the partial frame with no done_flag pulse.

Structure
REQ-027 SHALL place the state enumeration, parity codes, baud codes and the four divisor constants in shared package rx_frame_pkg.
REQ-028 SHALL implement the 16x tick generator as sub-module rx_baud_tick, with inputs clk, reset, restart and baud select, and output tick.

Verification
REQ-029 SHALL cover: 9600 baud, even parity, frame 0xA5 with parity bit 0 -> data_out=A5, one done_flag pulse, error_flag=000, active_flag high for the whole frame.
REQ-030 SHALL cover: 9600 baud, odd parity, 0xA5 sent with parity bit 0 -> data_out=A5, error_flag=001.
REQ-031 SHALL cover: line low for 4*325 clocks, then high -> error_flag=010, no done_flag, data_out unchanged.
REQ-032 SHALL cover: 19200 baud, no parity, 0x3C with stop bit 0 -> data_out=3C, error_flag=100; a later 0x55 after the line returns high -> data_out=55, error_flag=000.
REQ-033 SHALL cover: reset pulsed during data bit 4 -> all outputs 0 within the same cycle; the next 0x81 frame is received cleanly.
REQ-034 SHALL cover: baud_rate changed from 10 to 00 mid-frame -> the current frame completes at 9600; the next frame is received at 2400.
